// File: rtl/cache_fill_arbiter.sv
// Shared memory-port arbiter: store write-through and 8-word I/D cache block refills.
// Optional macro PERF_CNT_EN adds saturating per-cache fill-completion counters.
module cache_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned ADDR_W          = 16,
  localparam int unsigned IdxW           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid,
  output logic              fill_word_we,
  output logic [IdxW-1:0]   fill_word_idx,
  output logic              fill_tag_we,
  output logic              fill_dst,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]       i_fill_cnt,
  output logic [15:0]       d_fill_cnt
`endif
);

  localparam int unsigned BaseW = ADDR_W - IdxW - 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("MEM_LATENCY must be at least 1");
  end
  if ((1 << IdxW) != WORDS_PER_BLOCK) begin : g_wpb_chk
    $error("WORDS_PER_BLOCK must be a power of 2");
  end

  typedef enum logic [2:0] {StIdle, StWrite, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [IdxW-1:0]   ret_cnt_q, ret_cnt_d;
  logic [BaseW-1:0]  base_q, base_d;
  logic              dst_q, dst_d;
  logic              ret_fire;

  // Word-offset bits of the miss addresses are irrelevant: fills are block aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[IdxW:0], d_miss_addr[IdxW:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
      dst_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
      dst_q       <= dst_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    base_d        = base_q;
    dst_d         = dst_q;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fill_word_we  = 1'b0;
    fill_word_idx = '0;
    fill_tag_we   = 1'b0;
    i_fill_done   = 1'b0;
    d_fill_done   = 1'b0;
    d_wr_ack      = 1'b0;
    // Returns are only meaningful while a fill is outstanding; stale ones are dropped.
    ret_fire      = mem_data_valid && (state_q == StIssue || state_q == StDrain);

    unique case (state_q)
      StIdle: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (d_wr_req) begin
          state_d = StWrite;
        end else if (d_miss) begin
          base_d  = d_miss_addr[ADDR_W-1:IdxW+1];
          dst_d   = 1'b1;
          state_d = StIssue;
        end else if (i_miss) begin
          base_d  = i_miss_addr[ADDR_W-1:IdxW+1];
          dst_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StWrite: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = StIdle;
      end
      StIssue: begin
        mem_en      = 1'b1;
        mem_addr    = {base_q, issue_cnt_q, 1'b0};
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LastIdx) state_d = StDrain;
      end
      StDrain: ;
      StDone: begin
        fill_tag_we = 1'b1;
        i_fill_done = !dst_q;
        d_fill_done = dst_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ret_fire) begin
      fill_word_we  = 1'b1;
      fill_word_idx = ret_cnt_q;
      ret_cnt_d     = ret_cnt_q + 1'b1;
      if (ret_cnt_q == LastIdx) state_d = StDone;
    end
  end

  assign busy     = (state_q != StIdle);
  assign fill_dst = dst_q && (state_q == StIssue || state_q == StDrain || state_q == StDone);

`ifdef PERF_CNT_EN
  logic [15:0] i_cnt_q, d_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (i_fill_done && i_cnt_q != 16'hFFFF) i_cnt_q <= i_cnt_q + 16'd1;
      if (d_fill_done && d_cnt_q != 16'hFFFF) d_cnt_q <= d_cnt_q + 16'd1;
    end
  end

  assign i_fill_cnt = i_cnt_q;
  assign d_fill_cnt = d_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Random + directed bench for cache_fill_arbiter; reference model predicts every output
// each cycle from grant time and memory latency arithmetic.
module tb_cache_fill_arbiter;

  logic        clk, rst_n;
  logic        i_miss, d_miss, d_wr_req, mem_data_valid;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, fill_word_we, fill_tag_we, fill_dst;
  logic        i_fill_done, d_fill_done, d_wr_ack, busy;
  logic [15:0] mem_addr, mem_wdata;
  logic [2:0]  fill_word_idx;
`ifdef PERF_CNT_EN
  logic [15:0] i_fill_cnt, d_fill_cnt;
`endif

  cache_fill_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_miss        (i_miss),
    .i_miss_addr   (i_miss_addr),
    .d_miss        (d_miss),
    .d_miss_addr   (d_miss_addr),
    .d_wr_req      (d_wr_req),
    .d_wr_addr     (d_wr_addr),
    .d_wr_data     (d_wr_data),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_valid(mem_data_valid),
    .fill_word_we  (fill_word_we),
    .fill_word_idx (fill_word_idx),
    .fill_tag_we   (fill_tag_we),
    .fill_dst      (fill_dst),
    .i_fill_done   (i_fill_done),
    .d_fill_done   (d_fill_done),
    .d_wr_ack      (d_wr_ack),
    .busy          (busy)
`ifdef PERF_CNT_EN
    ,
    .i_fill_cnt    (i_fill_cnt),
    .d_fill_cnt    (d_fill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: one transaction in flight (0 none, 1 store, 2 D fill, 3 I fill).
  int          m_kind = 0;
  int          m_g = 0;
  int          m_lat = 4;
  int          force_lat = 4;
  logic [11:0] m_base = '0;
  int          i_cnt_m = 0;
  int          d_cnt_m = 0;
  bit          valid_at[int];

  // Requester bookkeeping.
  bit          rnd_en = 0;
  bit          i_act = 0, d_act = 0, w_act = 0;
  bit          drop_i = 0, drop_d = 0, drop_w = 0;
  bit          nxt_i = 0, nxt_d = 0, nxt_w = 0;
  logic [15:0] nxt_i_addr, nxt_d_addr, nxt_w_addr, nxt_w_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [43:0] obs();
    return {mem_en, mem_wr, mem_addr, mem_wdata, fill_word_we, fill_word_idx, fill_tag_we,
            fill_dst, i_fill_done, d_fill_done, d_wr_ack, busy};
  endfunction

  function automatic int pick_lat();
    return (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
  endfunction

  task automatic model_eval(output logic [43:0] e);
    logic        men, mwr, fwe, ftag, fdst, idn, ddn, ack, bsy;
    logic [15:0] ma, mwd;
    logic [2:0]  fidx;
    int          o;
    {men, mwr, fwe, ftag, fdst, idn, ddn, ack, bsy} = '0;
    ma = '0; mwd = '0; fidx = '0;
    if (m_kind == 0) begin
      if (d_wr_req) begin
        m_kind = 1; m_g = cyc;
      end else if (d_miss) begin
        m_kind = 2; m_g = cyc; m_base = d_miss_addr[15:4]; m_lat = pick_lat();
      end else if (i_miss) begin
        m_kind = 3; m_g = cyc; m_base = i_miss_addr[15:4]; m_lat = pick_lat();
      end
    end else begin
      o = cyc - m_g;
      bsy = 1'b1;
      if (m_kind == 1) begin
        men = 1'b1; mwr = 1'b1; ma = d_wr_addr; mwd = d_wr_data; ack = 1'b1;
        m_kind = 0; drop_w = 1;
      end else begin
        fdst = (m_kind == 2);
        if (o >= 1 && o <= 8) begin
          men = 1'b1;
          ma  = {m_base, 4'b0000} + 16'(2 * (o - 1));
        end
        if (o > m_lat && o <= 8 + m_lat) begin
          fwe  = 1'b1;
          fidx = 3'(o - 1 - m_lat);
        end
        if (o == 9 + m_lat) begin
          ftag = 1'b1;
          if (m_kind == 2) begin
            ddn = 1'b1; drop_d = 1; if (d_cnt_m < 65535) d_cnt_m++;
          end else begin
            idn = 1'b1; drop_i = 1; if (i_cnt_m < 65535) i_cnt_m++;
          end
          m_kind = 0;
        end
      end
    end
    e = {men, mwr, ma, mwd, fwe, fidx, ftag, fdst, idn, ddn, ack, bsy};
  endtask

  task automatic gen_random();
    if (!w_act && $urandom_range(0, 9) == 0) begin
      d_wr_req = 1; d_wr_addr = 16'($urandom) & 16'hFFFE; d_wr_data = 16'($urandom); w_act = 1;
    end
    if (!d_act && $urandom_range(0, 13) == 0) begin
      d_miss = 1; d_miss_addr = 16'($urandom); d_act = 1;
    end
    if (!i_act && $urandom_range(0, 11) == 0) begin
      i_miss = 1; i_miss_addr = 16'($urandom); i_act = 1;
    end
    // Flush: a granted fill keeps going even when its requester lets go.
    if (m_kind == 2 && d_miss && $urandom_range(0, 29) == 0) d_miss = 0;
    if (m_kind == 3 && i_miss && $urandom_range(0, 29) == 0) i_miss = 0;
  endtask

  task automatic tick();
    logic [43:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_en) gen_random();
    if (drop_i) begin i_miss = 0; i_act = 0; drop_i = 0; end
    if (drop_d) begin d_miss = 0; d_act = 0; drop_d = 0; end
    if (drop_w) begin d_wr_req = 0; w_act = 0; drop_w = 0; end
    if (nxt_i) begin i_miss = 1; i_miss_addr = nxt_i_addr; i_act = 1; nxt_i = 0; end
    if (nxt_d) begin d_miss = 1; d_miss_addr = nxt_d_addr; d_act = 1; nxt_d = 0; end
    if (nxt_w) begin
      d_wr_req = 1; d_wr_addr = nxt_w_addr; d_wr_data = nxt_w_data; w_act = 1; nxt_w = 0;
    end
    // Stray returns while no fill is outstanding must be ignored.
    mem_data_valid = valid_at.exists(cyc) ||
                     (rnd_en && (m_kind == 0 || m_kind == 1) && $urandom_range(0, 5) == 0);
    model_eval(e);
    @(negedge clk);
    check($sformatf("cyc%0d", cyc), 64'(obs()), 64'(e));
    if (mem_en && !mem_wr) valid_at[cyc + m_lat] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    {i_miss, d_miss, d_wr_req, mem_data_valid} = '0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    #2 rst_n = 1'b0;
    #1 check("reset", 64'(obs()), 64'd0);
    @(posedge clk);
    #1 check("reset_hold", 64'(obs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // I fill from 0x1236, latency 4.
    force_lat = 4;
    nxt_i = 1; nxt_i_addr = 16'h1236;
    repeat (16) tick();

    // Simultaneous D and I misses: D first, I right after D's done.
    nxt_i = 1; nxt_i_addr = 16'h0A42;
    nxt_d = 1; nxt_d_addr = 16'h8040;
    repeat (32) tick();

    // Store from idle.
    nxt_w = 1; nxt_w_addr = 16'h0010; nxt_w_data = 16'hBEEF;
    repeat (4) tick();

    // Store and D miss arrive during an I fill: store wins after I completes.
    nxt_i = 1; nxt_i_addr = 16'h2000;
    repeat (3) tick();
    nxt_w = 1; nxt_w_addr = 16'h0452; nxt_w_data = 16'h1234;
    nxt_d = 1; nxt_d_addr = 16'h3456;
    repeat (40) tick();

    // Reset in cycle 6 of a fill; stale returns afterwards must not write.
    nxt_i = 1; nxt_i_addr = 16'h4A5C;
    repeat (6) tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_valid = valid_at.exists(cyc);
    rst_n = 1'b0;
    i_miss = 0;
    #1 check("rst_mid_fill", 64'(obs()), 64'd0);
    {i_act, d_act, w_act, drop_i, drop_d, drop_w} = '0;
    m_kind = 0; i_cnt_m = 0; d_cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();

    // Random traffic with random per-fill latency and stray returns.
    force_lat = 0;
    rnd_en = 1;
    repeat (3000) tick();
    rnd_en = 0;
    repeat (100) tick();

`ifdef PERF_CNT_EN
    check("i_fill_cnt", 64'(i_fill_cnt), 64'(i_cnt_m));
    check("d_fill_cnt", 64'(d_fill_cnt), 64'(d_cnt_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
